// File: rtl/mac_dot_seq.sv
// Dot-product sequencer driving one 18x18 multiply-add/sub accumulator.
// Define MAC_SEQ_OVF_EN to add the res_ovf range check on the result.
module mac_dot_seq #(
  parameter int LEN_W = 8,
  parameter int OUT_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [53:0]      cmd_bias,
  input  logic             cmd_signed,
  input  logic             cmd_sub,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [17:0]      op_a,
  input  logic [17:0]      op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [53:0]      res_data,
  output logic             busy
`ifdef MAC_SEQ_OVF_EN
  ,
  output logic             res_ovf
`endif
);

  if (OUT_W < 2 || OUT_W > 53) begin : g_bad_outw
    $error("mac_dot_seq: OUT_W must be in 2..53");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_BIAS,
    S_RUN,
    S_DONE
  } state_e;

  state_e state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic first_q, first_d;
  logic [53:0] bias_q, bias_d;
  logic sgn_q, sgn_d;
  logic sub_q, sub_d;
  logic [53:0] z_q, z_d;

  logic step, loadc;
  logic [17:0] mul_a, mul_b;
  logic cmd_rdy_c, op_rdy_c, res_vld_c;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    bias_d    = bias_q;
    sgn_d     = sgn_q;
    sub_d     = sub_q;
    step      = 1'b0;
    loadc     = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    cmd_rdy_c = 1'b0;
    op_rdy_c  = 1'b0;
    res_vld_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cmd_rdy_c = 1'b1;
        if (cmd_valid) begin
          cnt_d   = cmd_len;
          first_d = 1'b1;
          bias_d  = cmd_bias;
          sgn_d   = cmd_signed;
          sub_d   = cmd_sub;
          state_d = (cmd_len == '0) ? S_BIAS : S_RUN;
        end
      end
      S_BIAS: begin
        step    = 1'b1;
        loadc   = 1'b1;
        state_d = S_DONE;
      end
      S_RUN: begin
        op_rdy_c = 1'b1;
        if (op_valid) begin
          step    = 1'b1;
          loadc   = first_q;
          mul_a   = op_a;
          mul_b   = op_b;
          first_d = 1'b0;
          cnt_d   = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        res_vld_c = 1'b1;
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Accumulator: Z <= (LOADC ? C : Z) +/- ext(A*B), wrapping at 54 bits
  logic signed [35:0] prod_s;
  logic [35:0] prod_u;
  logic [53:0] prod_x, acc_base;

  assign prod_s = $signed({{18{mul_a[17]}}, mul_a})
                * $signed({{18{mul_b[17]}}, mul_b});
  assign prod_u = {18'b0, mul_a} * {18'b0, mul_b};
  assign prod_x = sgn_q ? {{18{prod_s[35]}}, prod_s}
                        : {18'b0, prod_u};
  assign acc_base = loadc ? bias_q : z_q;

  always_comb begin
    z_d = z_q;
    if (step) z_d = sub_q ? acc_base - prod_x : acc_base + prod_x;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      first_q <= 1'b0;
      bias_q  <= '0;
      sgn_q   <= 1'b0;
      sub_q   <= 1'b0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      bias_q  <= bias_d;
      sgn_q   <= sgn_d;
      sub_q   <= sub_d;
      z_q     <= z_d;
    end
  end

  assign cmd_ready = rst_n & cmd_rdy_c;
  assign op_ready  = rst_n & op_rdy_c;
  assign res_valid = rst_n & res_vld_c;
  assign busy      = rst_n & (state_q != S_IDLE);
  assign res_data  = z_q;

`ifdef MAC_SEQ_OVF_EN
  // Upper bits must be pure sign extension (signed) or zero (unsigned)
  logic fits;
  always_comb begin
    if (sgn_q) fits = (&z_q[53:OUT_W-1]) | ~(|z_q[53:OUT_W-1]);
    else       fits = ~(|z_q[53:OUT_W]);
  end
  assign res_ovf = res_valid & ~fits;
`endif

endmodule

// File: tb/tb_mac_dot_seq.sv
// Scoreboard bench for mac_dot_seq: jobs drive a reference accumulator,
// expected results are queued and popped when the DUT presents a result.
module tb_mac_dot_seq;
  localparam int LEN_W = 8;
  localparam int OUT_W = 48;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             cmd_valid, cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic [53:0]      cmd_bias;
  logic             cmd_signed, cmd_sub;
  logic             op_valid, op_ready;
  logic [17:0]      op_a, op_b;
  logic             res_valid, res_ready;
  logic [53:0]      res_data;
  logic             busy;
`ifdef MAC_SEQ_OVF_EN
  logic             res_ovf;
`endif

  mac_dot_seq #(.LEN_W(LEN_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .cmd_bias  (cmd_bias),
    .cmd_signed(cmd_signed),
    .cmd_sub   (cmd_sub),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy)
`ifdef MAC_SEQ_OVF_EN
    ,
    .res_ovf   (res_ovf)
`endif
  );

  typedef struct {
    logic [53:0] d;
    logic        s;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  logic [53:0] acc;
  logic        job_sgn, job_sub;

  task automatic chk(input string tag, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [53:0] term(input logic [17:0] a,
                                       input logic [17:0] b,
                                       input logic s);
    logic signed [53:0] sa, sb2;
    logic [53:0] ua, ub;
    sa  = {{36{a[17]}}, a};
    sb2 = {{36{b[17]}}, b};
    ua  = {36'b0, a};
    ub  = {36'b0, b};
    return s ? 54'(sa * sb2) : 54'(ua * ub);
  endfunction

  function automatic logic ovf_of(input logic [53:0] z, input logic s);
    longint v, lim;
    lim = 64'sd1 <<< (OUT_W - 1);
    if (s) begin
      v = longint'($signed(z));
      return (v > lim - 1) || (v < -lim);
    end
    v = longint'({10'b0, z});
    return v > (2 * lim) - 1;
  endfunction

  task automatic send_cmd(input logic [LEN_W-1:0] len,
                          input logic [53:0] bias,
                          input logic sgn, input logic sub);
    cmd_len    = len;
    cmd_bias   = bias;
    cmd_signed = sgn;
    cmd_sub    = sub;
    cmd_valid  = 1'b1;
    for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge clk);
    chk("cmd_timeout", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    acc     = bias;
    job_sgn = sgn;
    job_sub = sub;
    chk("op_rdy_lat", op_ready, len != '0);
    chk("busy", busy, 1);
    if (len == '0) sb.push_back('{d: bias, s: sgn});
  endtask

  task automatic send_op(input logic [17:0] a, input logic [17:0] b,
                         input bit last, input int gap);
    logic [53:0] t;
    op_a     = a;
    op_b     = b;
    op_valid = 1'b1;
    for (int i = 0; i < 100 && !op_ready; i++) @(negedge clk);
    chk("op_timeout", op_ready, 1);
    @(negedge clk);
    t   = term(a, b, job_sgn);
    acc = job_sub ? acc - t : acc + t;
    if (last || gap > 0) op_valid = 1'b0;
    if (last) begin
      chk("res_lat", res_valid, 1);
      sb.push_back('{d: acc, s: job_sgn});
    end
    repeat (gap) @(negedge clk);
  endtask

  task automatic get_result(input string tag, input int hold);
    exp_t e;
    res_ready = 1'b0;
    for (int i = 0; i < 100 && !res_valid; i++) @(negedge clk);
    chk({tag, "_vld"}, res_valid, 1);
    chk({tag, "_sb"}, 64'(sb.size() > 0), 1);
    e = (sb.size() > 0) ? sb[0] : '{d: '0, s: 1'b0};
    repeat (hold) begin
      @(negedge clk);
      chk({tag, "_hold"}, {res_valid, res_data}, {1'b1, e.d});
    end
    res_ready = 1'b1;
    if (sb.size() > 0) void'(sb.pop_front());
    chk(tag, res_data, e.d);
`ifdef MAC_SEQ_OVF_EN
    chk({tag, "_ovf"}, res_ovf, ovf_of(e.d, e.s));
`endif
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_clr"}, res_valid, 0);
    chk({tag, "_idle"}, cmd_ready, 1);
  endtask

  initial begin
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_len    = '0;
    cmd_bias   = '0;
    cmd_signed = 1'b0;
    cmd_sub    = 1'b0;
    op_valid   = 1'b0;
    op_a       = '0;
    op_b       = '0;
    res_ready  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_rdy", cmd_ready, 0);
    chk("rst_op_rdy", op_ready, 0);
    chk("rst_res_vld", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", res_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", cmd_ready, 1);

    // unsigned back-to-back, 44
    send_cmd(3, 54'd0, 0, 0);
    send_op(18'd1, 18'd2, 0, 0);
    chk("cmd_blocked", cmd_ready, 0);
    send_op(18'd3, 18'd4, 0, 0);
    send_op(18'd5, 18'd6, 1, 0);
    chk("t1_const", res_data, 54'd44);
    get_result("t1", 0);

    // signed, 10 + (-3*5)
    send_cmd(1, 54'd10, 1, 0);
    send_op(18'h3FFFD, 18'd5, 1, 0);
    chk("t2_const", res_data, 54'h3F_FFFF_FFFF_FFFB);
    get_result("t2", 0);

    // len=0 with stray op_valid
    op_valid = 1'b1;
    op_a     = 18'd9;
    op_b     = 18'd9;
    send_cmd(0, 54'h123, 0, 0);
    chk("t3_bias_vld", res_valid, 0);
    @(negedge clk);
    chk("t3_lat", res_valid, 1);
    chk("t3_no_op_rdy", op_ready, 0);
    op_valid = 1'b0;
    get_result("t3", 0);

    // backpressure, subtract: 100-4-9
    send_cmd(2, 54'd100, 0, 1);
    send_op(18'd2, 18'd2, 0, 1);
    send_op(18'd3, 18'd3, 1, 1);
    chk("t4_const", res_data, 54'd87);
    get_result("t4", 5);

    // reset mid-job
    send_cmd(4, 54'd0, 0, 0);
    send_op(18'd1, 18'd1, 0, 0);
    send_op(18'd2, 18'd2, 0, 0);
    rst_n    = 1'b0;
    op_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_vld", res_valid, 0);
    chk("mid_rst_oprdy", op_ready, 0);
    chk("mid_rst_data", res_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_idle", {busy, cmd_ready}, 2'b01);
    send_cmd(1, 54'd0, 0, 0);
    send_op(18'd7, 18'd7, 1, 0);
    chk("t5_const", res_data, 54'd49);
    get_result("t5", 0);

    // 48-bit signed range edge
    send_cmd(1, (54'd1 << 47) - 54'd1, 1, 0);
    send_op(18'd1, 18'd1, 1, 0);
    get_result("ovf1", 0);
    send_cmd(1, 54'd0, 1, 0);
    send_op(18'd1, 18'd1, 1, 0);
    get_result("ovf0", 0);

    // full-length job
    send_cmd(LEN_W'(255), 54'd0, 0, 0);
    for (int i = 0; i < 255; i++)
      send_op(18'(i + 1), 18'd3, i == 254, 0);
    chk("tmax_const", res_data, 54'd97920);
    get_result("tmax", 0);

    // random jobs
    for (int j = 0; j < 6; j++) begin
      int len;
      len = $urandom_range(1, 6);
      send_cmd(LEN_W'(len), {22'($urandom), 32'($urandom)},
               1'($urandom), 1'($urandom));
      for (int k = 0; k < len; k++)
        send_op(18'($urandom), 18'($urandom), k == len - 1,
                $urandom_range(0, 1));
      get_result("rnd", $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
